sha1_msg_wr_sched: RTL and testbench

SHA1_MSG_WR_SCHED -- requirements
Module: sha1_msg_wr_sched

---
 rtl/sha1_msg_wr_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_sha1_msg_wr_sched.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_msg_wr_sched.sv
// Message RAM write scheduler: arbitrates requester packets into free RAM slots and streams their blocks.
// Define SHA1_WR_SCHED_STRICT_PRI_EN for fixed priority (port 0 highest) instead of round-robin grant.

module sha1_msg_wr_lane #(
  parameter int TAG_W = 14,
  parameter int MSG_W = 512
) (
  input  logic             sel,
  input  logic             rdy_en,
  input  logic             valid,
  input  logic [5:0]       len,
  input  logic [TAG_W-1:0] tag,
  input  logic [MSG_W-1:0] data,
  output logic             ready,
  output logic [5:0]       len_m,
  output logic [TAG_W-1:0] tag_m,
  output logic [MSG_W-1:0] data_m
);
  // Unselected lanes contribute zero so the top can OR-reduce them
  assign ready  = sel & rdy_en & valid;
  assign len_m  = sel ? len  : '0;
  assign tag_m  = sel ? tag  : '0;
  assign data_m = sel ? data : '0;
endmodule

module sha1_msg_wr_sched #(
  parameter int REQ_NUM           = 4,
  parameter int CHANNEL_NUM_TOTAL = 64,
  parameter int TAG_DATA_WIDTH    = 14,
  parameter int MSG_DATA_WIDTH    = 512,
  parameter int CHANNEL_NUM_WIDTH = $clog2(CHANNEL_NUM_TOTAL)
) (
  input  logic                               sys_clk,
  input  logic                               sys_rst,
  input  logic [REQ_NUM-1:0]                 req_valid,
  input  logic [REQ_NUM*6-1:0]               req_len,
  input  logic [REQ_NUM*TAG_DATA_WIDTH-1:0]  req_tag,
  input  logic [REQ_NUM*MSG_DATA_WIDTH-1:0]  req_data,
  output logic [REQ_NUM-1:0]                 req_ready,
  input  logic                               slot_free_ena,
  input  logic [CHANNEL_NUM_WIDTH-1:0]       slot_free_id,
  output logic [MSG_DATA_WIDTH-1:0]          msg_wr_data,
  output logic                               msg_wr_ena,
  output logic                               msg_wr_sop,
  output logic [11:0]                        msg_wr_addr,
  output logic [5:0]                         msg_wr_len,
  output logic [TAG_DATA_WIDTH-1:0]          msg_wr_tag,
  output logic [CHANNEL_NUM_WIDTH:0]         slot_free_cnt,
  output logic                               err_len,
  output logic                               err_double_free
);
  localparam int CW = CHANNEL_NUM_WIDTH;
  localparam int PW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  typedef enum logic {IDLE, XFER} state_t;

  typedef struct packed {
    logic [PW-1:0]             port;
    logic [CW-1:0]             slot;
    logic [5:0]                len;
    logic [TAG_DATA_WIDTH-1:0] tag;
  } ctx_t;

  typedef struct packed {
    logic [MSG_DATA_WIDTH-1:0] data;
    logic [11:0]               addr;
    logic [5:0]                len;
    logic [TAG_DATA_WIDTH-1:0] tag;
  } wr_t;

  state_t                    state, state_nxt;
  ctx_t                      ctx;
  wr_t                       wr_q;
  logic [5:0]                beat_cnt;
  logic [CHANNEL_NUM_TOTAL-1:0] free_q, free_nxt;
  logic [CW:0]               cnt_nxt;
  logic [CW-1:0]             alloc_slot;
  logic [PW-1:0]             gnt_idx;
  logic                      gnt_found, grant, accept, last, ret, rel, dbl;

  logic [REQ_NUM-1:0]                     lane_sel;
  logic [REQ_NUM-1:0][5:0]                lane_len;
  logic [REQ_NUM-1:0][TAG_DATA_WIDTH-1:0] lane_tag;
  logic [REQ_NUM-1:0][MSG_DATA_WIDTH-1:0] lane_data;
  logic [5:0]                mux_len;
  logic [TAG_DATA_WIDTH-1:0] mux_tag;
  logic [MSG_DATA_WIDTH-1:0] mux_data;
  logic                      rdy_en;

`ifndef SHA1_WR_SCHED_STRICT_PRI_EN
  logic [PW-1:0] rr_ptr;
`endif

  assign rdy_en = (state == XFER) && !sys_rst;

  for (genvar i = 0; i < REQ_NUM; i++) begin : g_lane
    assign lane_sel[i] = (state == IDLE) ? (gnt_idx == PW'(i)) : (ctx.port == PW'(i));
    sha1_msg_wr_lane #(.TAG_W(TAG_DATA_WIDTH), .MSG_W(MSG_DATA_WIDTH)) u_lane (
      .sel    (lane_sel[i]),
      .rdy_en (rdy_en),
      .valid  (req_valid[i]),
      .len    (req_len[i*6 +: 6]),
      .tag    (req_tag[i*TAG_DATA_WIDTH +: TAG_DATA_WIDTH]),
      .data   (req_data[i*MSG_DATA_WIDTH +: MSG_DATA_WIDTH]),
      .ready  (req_ready[i]),
      .len_m  (lane_len[i]),
      .tag_m  (lane_tag[i]),
      .data_m (lane_data[i])
    );
  end

  always_comb begin
    mux_len  = '0;
    mux_tag  = '0;
    mux_data = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      mux_len  = mux_len  | lane_len[i];
      mux_tag  = mux_tag  | lane_tag[i];
      mux_data = mux_data | lane_data[i];
    end
  end

  // Grant search starts at the port after the last grant (or port 0 in strict mode)
  always_comb begin
    logic [PW:0] p;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    p         = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
`ifdef SHA1_WR_SCHED_STRICT_PRI_EN
      p = (PW+1)'(i);
`else
      p = {1'b0, rr_ptr} + (PW+1)'(i);
      if (p >= (PW+1)'(REQ_NUM)) p = p - (PW+1)'(REQ_NUM);
`endif
      if (!gnt_found && req_valid[p[PW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = p[PW-1:0];
      end
    end
  end

  always_comb begin
    alloc_slot = '0;
    for (int s = CHANNEL_NUM_TOTAL-1; s >= 0; s--)
      if (free_q[s]) alloc_slot = CW'(s);
  end

  assign grant  = (state == IDLE) && gnt_found && (slot_free_cnt != '0);
  assign accept = (state == XFER) && req_valid[ctx.port];
  assign last   = accept && ((ctx.len == 6'd0) || (beat_cnt == ctx.len - 6'd1));
  assign ret    = accept && (ctx.len == 6'd0);
  assign rel    = slot_free_ena && !free_q[slot_free_id];
  assign dbl    = slot_free_ena &&  free_q[slot_free_id];

  // Release, allocation and zero-length return never touch the same slot in one cycle
  always_comb begin
    free_nxt = free_q;
    if (rel)   free_nxt[slot_free_id] = 1'b1;
    if (grant) free_nxt[alloc_slot]   = 1'b0;
    if (ret)   free_nxt[ctx.slot]     = 1'b1;
    cnt_nxt = '0;
    for (int s = 0; s < CHANNEL_NUM_TOTAL; s++)
      cnt_nxt = cnt_nxt + (CW+1)'(free_nxt[s]);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = XFER;
      XFER:    if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state           <= IDLE;
      free_q          <= '1;
      slot_free_cnt   <= (CW+1)'(CHANNEL_NUM_TOTAL);
      ctx             <= '0;
      beat_cnt        <= '0;
      wr_q            <= '0;
      msg_wr_ena      <= 1'b0;
      msg_wr_sop      <= 1'b0;
      err_len         <= 1'b0;
      err_double_free <= 1'b0;
`ifndef SHA1_WR_SCHED_STRICT_PRI_EN
      rr_ptr          <= '0;
`endif
    end else begin
      state           <= state_nxt;
      free_q          <= free_nxt;
      slot_free_cnt   <= cnt_nxt;
      msg_wr_ena      <= accept && (ctx.len != 6'd0);
      msg_wr_sop      <= accept && (ctx.len != 6'd0) && (beat_cnt == 6'd0);
      err_len         <= ret;
      err_double_free <= dbl;
      if (grant) begin
        ctx.port <= gnt_idx;
        ctx.slot <= alloc_slot;
        ctx.len  <= mux_len;
        ctx.tag  <= mux_tag;
        beat_cnt <= '0;
`ifndef SHA1_WR_SCHED_STRICT_PRI_EN
        rr_ptr   <= (gnt_idx == PW'(REQ_NUM-1)) ? '0 : gnt_idx + PW'(1);
`endif
      end
      if (accept) begin
        beat_cnt <= beat_cnt + 6'd1;
        if (ctx.len != 6'd0) begin
          wr_q.data <= mux_data;
          wr_q.addr <= 12'({ctx.slot, beat_cnt});
          wr_q.len  <= ctx.len;
          wr_q.tag  <= ctx.tag;
        end
      end
    end
  end

  assign msg_wr_data = wr_q.data;
  assign msg_wr_addr = wr_q.addr;
  assign msg_wr_len  = wr_q.len;
  assign msg_wr_tag  = wr_q.tag;
endmodule

// File: tb/tb_sha1_msg_wr_sched.sv
// Bench for sha1_msg_wr_sched: packet queues per port, a slot-pool/arbiter reference model, directed scenarios plus random traffic.
module tb_sha1_msg_wr_sched;
  localparam int RN = 4, CT = 64, CW = 6, TW = 14, MW = 512;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic [RN-1:0]     req_valid = '0;
  logic [RN*6-1:0]   req_len = '0;
  logic [RN*TW-1:0]  req_tag = '0;
  logic [RN*MW-1:0]  req_data = '0;
  logic [RN-1:0]     req_ready;
  logic              slot_free_ena = 1'b0;
  logic [CW-1:0]     slot_free_id = '0;
  logic [MW-1:0]     msg_wr_data;
  logic              msg_wr_ena, msg_wr_sop;
  logic [11:0]       msg_wr_addr;
  logic [5:0]        msg_wr_len;
  logic [TW-1:0]     msg_wr_tag;
  logic [CW:0]       slot_free_cnt;
  logic              err_len, err_double_free;

  sha1_msg_wr_sched dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req_valid(req_valid), .req_len(req_len),
    .req_tag(req_tag), .req_data(req_data), .req_ready(req_ready),
    .slot_free_ena(slot_free_ena), .slot_free_id(slot_free_id),
    .msg_wr_data(msg_wr_data), .msg_wr_ena(msg_wr_ena), .msg_wr_sop(msg_wr_sop),
    .msg_wr_addr(msg_wr_addr), .msg_wr_len(msg_wr_len), .msg_wr_tag(msg_wr_tag),
    .slot_free_cnt(slot_free_cnt), .err_len(err_len), .err_double_free(err_double_free)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0, errors = 0;

  // Reference model: free set, round-robin start, current packet
  bit [CT-1:0] m_free;
  int  m_rr, m_port, m_slot, m_beat, m_len, m_tag;
  bit  m_busy;
  bit  e_ena, e_sop, e_errlen, e_dbl;
  int  e_addr, e_len, e_tag, e_cnt;
  logic [MW-1:0] e_data;

  int pk_len [RN][128];
  int pk_tag [RN][128];
  int pk_head [RN];
  int pk_tail [RN];
  logic [MW-1:0] beat_data [RN];

  bit drv_rst = 1'b1, drv_free_ena = 1'b0, gaps = 1'b0, chk_en = 1'b0;
  int drv_free_id = 0;
  int wr_log_addr[$];
  int wr_log_tag[$];
  int n_errlen = 0;

  task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MW-1:0] rnd_blk();
    logic [MW-1:0] r;
    for (int i = 0; i < MW/32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic bit pending();
    bit r = m_busy;
    for (int p = 0; p < RN; p++) if (pk_head[p] < pk_tail[p]) r = 1'b1;
    return r;
  endfunction

  task automatic push(input int p, input int len, input int tag);
    pk_len[p][pk_tail[p]] = len;
    pk_tag[p][pk_tail[p]] = tag;
    pk_tail[p]++;
  endtask

  task automatic cycle();
    logic [RN-1:0] v, er;
    bit [CT-1:0] nfree;
    int start, g, slot;
    bit found;
    @(negedge sys_clk);
    if (chk_en) begin
      check("wr_ena", msg_wr_ena, e_ena);
      if (e_ena) begin
        check("wr_addr", msg_wr_addr, e_addr);
        check("wr_data", msg_wr_data, e_data);
        check("wr_sop", msg_wr_sop, e_sop);
        check("wr_len", msg_wr_len, e_len);
        check("wr_tag", msg_wr_tag, e_tag);
      end
      check("err_len", err_len, e_errlen);
      check("err_double_free", err_double_free, e_dbl);
      check("slot_free_cnt", slot_free_cnt, e_cnt);
    end
    chk_en = 1'b1;
    if (msg_wr_ena === 1'b1) begin
      wr_log_addr.push_back(int'(msg_wr_addr));
      wr_log_tag.push_back(int'(msg_wr_tag));
    end
    if (err_len === 1'b1) n_errlen++;

    sys_rst = drv_rst;
    slot_free_ena = drv_free_ena;
    slot_free_id = CW'(drv_free_id);
    for (int p = 0; p < RN; p++) begin
      bit has = pk_head[p] < pk_tail[p];
      v[p] = has && (!gaps || $urandom_range(3) != 0);
      req_len[p*6 +: 6] = has ? 6'(pk_len[p][pk_head[p]]) : 6'd0;
      req_tag[p*TW +: TW] = has ? TW'(pk_tag[p][pk_head[p]]) : '0;
      req_data[p*MW +: MW] = beat_data[p];
    end
    req_valid = v;
    #1;
    er = '0;
    if (!drv_rst && m_busy) er[m_port] = v[m_port];
    check("req_ready", req_ready, er);

    e_ena = 0; e_sop = 0; e_errlen = 0; e_dbl = 0;
    if (drv_rst) begin
      m_free = '1; m_rr = 0; m_busy = 0; m_beat = 0;
      for (int p = 0; p < RN; p++) begin pk_head[p] = 0; pk_tail[p] = 0; end
      e_cnt = CT;
    end else begin
      nfree = m_free;
      if (drv_free_ena) begin
        if (m_free[drv_free_id]) e_dbl = 1; else nfree[drv_free_id] = 1'b1;
      end
      if (!m_busy) begin
`ifdef SHA1_WR_SCHED_STRICT_PRI_EN
        start = 0;
`else
        start = m_rr;
`endif
        found = 0; g = 0;
        for (int i = 0; i < RN; i++)
          if (!found && v[(start + i) % RN]) begin found = 1; g = (start + i) % RN; end
        if (found && $countones(m_free) > 0) begin
          slot = 0;
          for (int s = CT-1; s >= 0; s--) if (m_free[s]) slot = s;
          nfree[slot] = 1'b0;
          m_busy = 1; m_port = g; m_slot = slot; m_beat = 0;
          m_len = pk_len[g][pk_head[g]]; m_tag = pk_tag[g][pk_head[g]];
          m_rr = (g + 1) % RN;
        end
      end else if (v[m_port]) begin
        if (m_len == 0) begin
          e_errlen = 1; nfree[m_slot] = 1'b1; m_busy = 0; pk_head[m_port]++;
        end else begin
          e_ena = 1; e_sop = (m_beat == 0);
          e_addr = m_slot * 64 + m_beat; e_data = beat_data[m_port];
          e_len = m_len; e_tag = m_tag;
          m_beat++;
          if (m_beat == m_len) begin m_busy = 0; pk_head[m_port]++; end
        end
        beat_data[m_port] = rnd_blk();
      end
      m_free = nfree;
      e_cnt = $countones(nfree);
    end
  endtask

  task automatic run_n(input int n);
    repeat (n) cycle();
  endtask

  task automatic run_until_idle(input int max, input string tag);
    int n = 0;
    while (pending() && n < max) begin cycle(); n++; end
    check({tag, "_drain"}, pending(), 1'b0);
    run_n(2);
  endtask

  task automatic do_reset();
    drv_rst = 1; run_n(2); drv_rst = 0;
  endtask

  task automatic clear_log();
    wr_log_addr.delete(); wr_log_tag.delete(); n_errlen = 0;
  endtask

  initial begin
    for (int p = 0; p < RN; p++) begin pk_head[p] = 0; pk_tail[p] = 0; beat_data[p] = rnd_blk(); end
    m_free = '1; m_busy = 0; m_rr = 0;
    drv_rst = 1; run_n(3); drv_rst = 0;
    check("rst_addr", msg_wr_addr, 0);
    check("rst_data", msg_wr_data, 0);
    check("rst_sop", msg_wr_sop, 0);
    check("rst_len", msg_wr_len, 0);
    check("rst_tag", msg_wr_tag, 0);
    check("rst_cnt", slot_free_cnt, CT);

    // single 3-block packet from port 1
    clear_log();
    push(1, 3, 'h0A5);
    run_until_idle(40, "t_len3");
    check("t_len3_nwr", wr_log_addr.size(), 3);
    check("t_len3_a0", wr_log_addr[0], 'h000);
    check("t_len3_a1", wr_log_addr[1], 'h001);
    check("t_len3_a2", wr_log_addr[2], 'h002);
    check("t_len3_cnt", slot_free_cnt, 63);

    // two contending ports
    do_reset(); clear_log();
    for (int k = 0; k < 4; k++) begin push(0, 1, 'h100); push(2, 1, 'h102); end
    run_until_idle(60, "t_arb");
    begin
      int exp_tags [4];
`ifdef SHA1_WR_SCHED_STRICT_PRI_EN
      exp_tags = '{'h100, 'h100, 'h100, 'h100};
`else
      exp_tags = '{'h100, 'h102, 'h100, 'h102};
`endif
      for (int k = 0; k < 4; k++) check($sformatf("t_arb_tag%0d", k), wr_log_tag[k], exp_tags[k]);
    end

    // exhaust the pool, then release slot 5
    do_reset();
    for (int k = 0; k < CT; k++) push($urandom_range(RN-1), 1, $urandom_range(16383));
    run_until_idle(400, "t_full");
    check("t_full_cnt", slot_free_cnt, 0);
    push(3, 1, 'h33);
    run_n(6);
    check("t_full_ready", req_ready, '0);
    clear_log();
    drv_free_ena = 1; drv_free_id = 5; cycle(); drv_free_ena = 0;
    run_until_idle(20, "t_refill");
    check("t_refill_addr", wr_log_addr[0], 'h140);

    // double free of an idle slot
    do_reset();
    drv_free_ena = 1; drv_free_id = 10; cycle(); drv_free_ena = 0;
    cycle();
    check("t_dbl_pulse", err_double_free, 1);
    check("t_dbl_cnt", slot_free_cnt, CT);
    cycle();
    check("t_dbl_end", err_double_free, 0);

    // zero-length packet
    clear_log();
    push(3, 0, 'h3C);
    run_until_idle(20, "t_len0");
    check("t_len0_errs", n_errlen, 1);
    check("t_len0_nwr", wr_log_addr.size(), 0);
    check("t_len0_cnt", slot_free_cnt, CT);

    // reset in the middle of a packet
    do_reset();
    push(0, 5, 'h55);
    begin
      int n = 0;
      while (m_beat < 2 && n < 20) begin cycle(); n++; end
      check("t_mid_start", m_beat >= 2, 1'b1);
    end
    drv_rst = 1; run_n(2); drv_rst = 0;
    clear_log();
    run_n(6);
    check("t_mid_nwr", wr_log_addr.size(), 0);
    check("t_mid_cnt", slot_free_cnt, CT);

    // random traffic with valid gaps and random releases
    do_reset();
    gaps = 1;
    for (int p = 0; p < RN; p++)
      for (int k = 0; k < 25; k++) push(p, $urandom_range(4), $urandom_range(16383));
    for (int c = 0; c < 1500; c++) begin
      drv_free_ena = ($urandom_range(5) == 0);
      drv_free_id = $urandom_range(CT-1);
      cycle();
    end
    drv_free_ena = 0; gaps = 0;
    run_n(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
